burst_read_wf: RTL and testbench

Avalon-MM burst read master, the read-side companion of the team's burst write master. A single ctrl_start issues one burst read command of ctrl_burstcount beats from ctrl_baseaddress. Returned beats are registered and presented to the local consumer with a beat index, and completion is flagged with a done pulse. It sits between a local datapath (frame/line buffer logic) and the SDRAM controller's Avalon-MM slave port.

---
 rtl/burst_read_wf_pkg.sv | 18 +
 rtl/burst_read_wf.sv | 123 ++++++++++++
 tb/tb_burst_read_wf.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_read_wf_pkg.sv
// Shared definitions for the Avalon-MM burst read/write masters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package burst_read_wf_pkg;

    // Master FSM encoding, shared with the write-side master.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Widest byteenable we ever drive (1024-bit data); users slice
    // the low BYTE_ENABLE_WIDTH bits.
    localparam int                     MAX_BE_WIDTH = 128;
    localparam logic [MAX_BE_WIDTH-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/burst_read_wf.sv
// Avalon-MM burst read master: one ctrl_start issues one burst read, beats are registered out with their index.
// Latency: command visible 1 cycle after start; readdatavalid -> ctrl_readdatavalid exactly 1 cycle.
// Backpressure: command held while master_waitrequest=1; returned data cannot be stalled (no local ready).
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   master_*                          Avalon-MM read master towards the SDRAM controller
//   ctrl_start/baseaddress/burstcount burst request from the local datapath
//   ctrl_busy, ctrl_done              burst in progress / one-cycle completion pulse
//   ctrl_readdata/readdatavalid/address  registered beat data with beat index
module burst_read_wf
    import burst_read_wf_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_WIDTH       = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,

    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_read,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,
    input  logic [DATA_WIDTH-1:0]        master_readdata,
    input  logic                         master_readdatavalid,

    input  logic                         ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
    input  logic [BURST_WIDTH-1:0]       ctrl_burstcount,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic [DATA_WIDTH-1:0]        ctrl_readdata,
    output logic                         ctrl_readdatavalid,
    output logic [BURST_WIDTH-1:0]       ctrl_address
);

    localparam logic [BURST_WIDTH-1:0] ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_nxt;
    logic [BURST_WIDTH-1:0] beat_cnt;
    logic                   start_ok;
    logic                   cmd_accept;
    logic                   beat_vld;
    logic                   last_beat;

    assign master_byteenable = BE_ALL_ONES[BYTE_ENABLE_WIDTH-1:0];

    // Zero-length starts are dropped so busy never rises for them.
    assign start_ok   = (state == ST_IDLE) && ctrl_start && (ctrl_burstcount != '0);
    assign cmd_accept = (state == ST_REQ) && !master_waitrequest;
    // Returned data outside DATA is a slave protocol error and is ignored.
    assign beat_vld   = (state == ST_DATA) && master_readdatavalid;
    // master_burstcount doubles as the latched burst length.
    assign last_beat  = beat_vld && (beat_cnt == (master_burstcount - ONE));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok)   state_nxt = ST_REQ;
            ST_REQ:  if (cmd_accept) state_nxt = ST_DATA;
            ST_DATA: if (last_beat)  state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs: read is asserted for the whole REQ stall, and
    // busy drops on the same edge that raises ctrl_done.
    always_comb begin
        master_read = 1'b0;
        ctrl_busy   = 1'b0;
        case (state)
            ST_REQ: begin
                master_read = 1'b1;
                ctrl_busy   = 1'b1;
            end
            ST_DATA: ctrl_busy = 1'b1;
            default: ;
        endcase
    end

    // Command latch, beat counter and beat output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            master_address     <= '0;
            master_burstcount  <= '0;
            beat_cnt           <= '0;
            ctrl_readdata      <= '0;
            ctrl_address       <= '0;
            ctrl_readdatavalid <= 1'b0;
            ctrl_done          <= 1'b0;
        end else begin
            ctrl_readdatavalid <= 1'b0;
            ctrl_done          <= 1'b0;
            if (start_ok) begin
                master_address    <= ctrl_baseaddress;
                master_burstcount <= ctrl_burstcount;
                beat_cnt          <= '0;
            end
            if (beat_vld) begin
                ctrl_readdata      <= master_readdata;
                ctrl_address       <= beat_cnt;
                ctrl_readdatavalid <= 1'b1;
                ctrl_done          <= last_beat;
                beat_cnt           <= beat_cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_burst_read_wf.sv
module tb_burst_read_wf;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BEW = 4;
    localparam int BW  = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [AW-1:0]  master_address;
    logic           master_read;
    logic [BW-1:0]  master_burstcount;
    logic [BEW-1:0] master_byteenable;
    logic           master_waitrequest = 1'b0;
    logic [DW-1:0]  master_readdata = '0;
    logic           master_readdatavalid = 1'b0;
    logic           ctrl_start = 1'b0;
    logic [AW-1:0]  ctrl_baseaddress = '0;
    logic [BW-1:0]  ctrl_burstcount = '0;
    logic           ctrl_busy;
    logic           ctrl_done;
    logic [DW-1:0]  ctrl_readdata;
    logic           ctrl_readdatavalid;
    logic [BW-1:0]  ctrl_address;

    burst_read_wf #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_ENABLE_WIDTH(BEW), .BURST_WIDTH(BW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .master_address(master_address), .master_read(master_read),
        .master_burstcount(master_burstcount), .master_byteenable(master_byteenable),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .ctrl_start(ctrl_start), .ctrl_baseaddress(ctrl_baseaddress),
        .ctrl_burstcount(ctrl_burstcount), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .ctrl_readdata(ctrl_readdata), .ctrl_readdatavalid(ctrl_readdatavalid),
        .ctrl_address(ctrl_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] cnt;
    } cmd_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] idx;
        logic          done;
    } beat_t;

    cmd_t  exp_cmds[$];
    beat_t exp_beats[$];

    int checks   = 0;
    int failures = 0;
    bit model_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic          prev_read;
    logic          prev_wait;
    logic [AW-1:0] prev_addr;
    logic [BW-1:0] prev_cnt;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_read <= 1'b0;
            prev_wait <= 1'b0;
        end else begin
            if (prev_read && prev_wait) begin
                check("cmd_hold_read", master_read, 1);
                check("cmd_hold_addr", master_address, prev_addr);
                check("cmd_hold_cnt", master_burstcount, prev_cnt);
            end else if (prev_read) begin
                check("cmd_drop_after_accept", master_read, 0);
            end
            if (master_read && !master_waitrequest) begin
                if (exp_cmds.size() == 0) begin
                    check("cmd_unexpected", master_read, 0);
                end else begin
                    cmd_t c;
                    c = exp_cmds.pop_front();
                    check("cmd_addr", master_address, c.addr);
                    check("cmd_cnt", master_burstcount, c.cnt);
                    check("cmd_byteenable", master_byteenable, {BEW{1'b1}});
                end
            end
            if (ctrl_readdatavalid) begin
                if (exp_beats.size() == 0) begin
                    check("beat_unexpected", ctrl_readdatavalid, 0);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_data", ctrl_readdata, b.data);
                    check("beat_idx", ctrl_address, b.idx);
                    check("beat_done", ctrl_done, b.done);
                end
            end else if (ctrl_done) begin
                check("done_without_beat", ctrl_done, 0);
            end
            prev_read <= master_read;
            prev_wait <= master_waitrequest;
            prev_addr <= master_address;
            prev_cnt  <= master_burstcount;
        end
    end

    // ---------------- stimulus ----------------
    // Drives a one-cycle start; the model accepts it only when idle and count != 0.
    task automatic do_start(input logic [AW-1:0] addr, input int cnt);
        bit acc;
        acc = !model_busy && (cnt != 0);
        ctrl_start       = 1'b1;
        ctrl_baseaddress = addr;
        ctrl_burstcount  = BW'(cnt);
        if (acc) begin
            cmd_t c;
            c.addr = addr;
            c.cnt  = BW'(cnt);
            exp_cmds.push_back(c);
        end
        tick();
        ctrl_start       = 1'b0;
        // The DUT must use its latched copies from here on.
        ctrl_baseaddress = $urandom;
        ctrl_burstcount  = BW'($urandom);
        if (acc) begin
            model_busy = 1'b1;
            check("start_read", master_read, 1);
            check("start_addr", master_address, addr);
            check("start_busy", ctrl_busy, 1);
        end else if (!model_busy) begin
            check("zero_start_read", master_read, 0);
            check("zero_start_busy", ctrl_busy, 0);
        end else begin
            check("ignored_start_busy", ctrl_busy, 1);
            check("ignored_start_read", master_read, 0);
        end
    endtask

    // One complete burst: start, nwait stall cycles, gap idle cycles before
    // each beat, optional ignored start mid-burst. Returns in the done cycle.
    task automatic do_burst(input logic [AW-1:0] addr, input int cnt, input int nwait,
                            input int gap, input bit intrude,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        master_waitrequest = (nwait > 0);
        do_start(addr, cnt);
        repeat (nwait) tick();
        master_waitrequest = 1'b0;
        check("read_before_accept", master_read, 1);
        tick();
        check("read_after_accept", master_read, 0);
        if (intrude) do_start(32'h200, 2);
        for (int i = 0; i < cnt; i++) begin
            beat_t b;
            repeat (gap) begin
                tick();
                check("busy_in_gap", ctrl_busy, 1);
            end
            b.data = (i == 0) ? d0 : d1;
            b.idx  = BW'(i);
            b.done = (i == cnt - 1);
            exp_beats.push_back(b);
            master_readdatavalid = 1'b1;
            master_readdata      = b.data;
            tick();
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom;
            if (i < cnt - 1) begin
                check("busy_mid_burst", ctrl_busy, 1);
                check("no_early_done", ctrl_done, 0);
            end
        end
        model_busy = 1'b0;
        check("done_pulse", ctrl_done, 1);
        check("busy_clear_at_done", ctrl_busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"}, master_read, 0);
        check({tag, "_addr"}, master_address, 0);
        check({tag, "_cnt"}, master_burstcount, 0);
        check({tag, "_be"}, master_byteenable, {BEW{1'b1}});
        check({tag, "_busy"}, ctrl_busy, 0);
        check({tag, "_done"}, ctrl_done, 0);
        check({tag, "_rdata"}, ctrl_readdata, 0);
        check({tag, "_rvld"}, ctrl_readdatavalid, 0);
        check({tag, "_raddr"}, ctrl_address, 0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Basic burst
        do_burst(32'h100, 2, 0, 0, 1'b0, 32'hA1, 32'hB2);
        tick();
        check("basic_busy_after", ctrl_busy, 0);
        check("basic_done_after", ctrl_done, 0);

        // Waitrequest stall of 3 cycles
        do_burst(32'h140, 2, 3, 0, 1'b0, $urandom, $urandom);
        tick();

        // Gapped data
        do_burst(32'h180, 2, 0, 5, 1'b0, $urandom, $urandom);
        tick();

        // Zero-count start, then an ignored mid-burst start
        do_start(32'h1C0, 0);
        tick();
        do_burst(32'h300, 2, 1, 1, 1'b1, $urandom, $urandom);
        tick();

        // Back-to-back: new start in the done cycle
        do_burst(32'h400, 1, 0, 0, 1'b0, $urandom, $urandom);
        do_burst(32'h500, 2, 0, 0, 1'b0, $urandom, $urandom);
        tick();

        // Reset mid-burst after one beat
        begin
            beat_t b;
            do_start(32'h600, 2);
            tick();
            b.data = 32'hDEAD_0001;
            b.idx  = '0;
            b.done = 1'b0;
            exp_beats.push_back(b);
            master_readdatavalid = 1'b1;
            master_readdata      = b.data;
            tick();
            master_readdatavalid = 1'b0;
            tick();
            reset_n = 1'b0;
            model_busy = 1'b0;
            #2;
            check_all_zero("midreset");
            tick();
            reset_n = 1'b1;
            tick();
            master_readdatavalid = 1'b1;
            master_readdata      = 32'hBAD;
            tick();
            master_readdatavalid = 1'b0;
            check("stray_rvld", ctrl_readdatavalid, 0);
            check("stray_busy", ctrl_busy, 0);
            check("stray_done", ctrl_done, 0);
            tick();
        end

        // Randomized bursts
        for (int n = 0; n < 40; n++) begin
            int cnt;
            cnt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2));
            if (cnt == 0) begin
                do_start($urandom, 0);
            end else begin
                do_burst($urandom, cnt, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         ($urandom_range(0, 3) == 0), $urandom, $urandom);
            end
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) tick();
        end

        repeat (3) tick();
        check("cmds_left", 64'(exp_cmds.size()), 0);
        check("beats_left", 64'(exp_beats.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
